rle_encoder: RTL and testbench

- Optional run-length compressor between the sampler (dataOut/validOut) and sample_fifo data input.
- When enabled, each new sample value is written to the FIFO once. Repeats of that value are replaced by count words, which stretches capture depth for slow-changing signals.
- When disabled, samples pass through with one cycle of latency.
- Output word is one bit wider than the sample; the MSB is a flag: 0 = sample word, 1 = count word.

---
 rtl/rle_encoder.sv | 116 +++++++++++
 tb/tb_rle_encoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rle_encoder.sv
// rle_encoder: run-length compressor between sampler and sample FIFO, emits sample words and repeat-count words
module rle_encoder #(
  parameter int SAMPLE_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rle_en,
  input  logic [SAMPLE_WIDTH-1:0] data_in,
  input  logic                    valid_in,
  input  logic                    flush,
  output logic [SAMPLE_WIDTH:0]   data_out,
  output logic                    valid_out,
  output logic                    flush_done,
  output logic                    busy
);
  localparam int W = SAMPLE_WIDTH;
  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] SAT = {{(W-1){1'b1}}, 1'b0};
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t         r_state;
  logic [W-1:0]   r_last;
  logic [W-1:0]   r_count;
  logic [W-1:0]   r_pend;
  logic           r_pend_v;
  logic [W:0]     r_data_out;
  logic           r_valid_out;
  logic           r_flush_done;
  logic           r_busy;
  logic           w_drain;
  assign data_out   = r_data_out;
  assign valid_out  = r_valid_out;
  assign flush_done = r_flush_done;
  assign busy       = r_busy;
  // the flush cycle itself already starts draining, so an empty encoder finishes one cycle after flush
  assign w_drain = (r_state == FLUSH) || (r_state == RUN && flush);
  // encoder FSM: one output word per cycle; pend absorbs the sample displaced by a count word
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last       <= '0;
      r_count      <= '0;
      r_pend       <= '0;
      r_pend_v     <= 1'b0;
      r_data_out   <= '0;
      r_valid_out  <= 1'b0;
      r_flush_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_valid_out  <= 1'b0;
      r_flush_done <= 1'b0;
      if (w_drain) begin
        if (r_pend_v) begin
          r_data_out  <= {1'b0, r_pend};
          r_valid_out <= 1'b1;
          r_pend_v    <= 1'b0;
          r_state     <= FLUSH;
          r_busy      <= 1'b1;
        end else if (r_count != '0) begin
          r_data_out  <= {1'b1, r_count};
          r_valid_out <= 1'b1;
          r_count     <= '0;
          r_state     <= FLUSH;
          r_busy      <= 1'b1;
        end else begin
          r_flush_done <= 1'b1;
          r_state      <= IDLE;
          r_busy       <= 1'b0;
        end
      end else if (r_state == IDLE) begin
        if (flush) begin
          r_flush_done <= 1'b1;
        end else if (valid_in) begin
          r_data_out  <= {1'b0, data_in};
          r_valid_out <= 1'b1;
          if (rle_en) begin
            r_last  <= data_in;
            r_count <= '0;
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
        end
      end else if (valid_in && data_in == r_last) begin
        if (r_count == SAT) begin
          r_data_out  <= {1'b1, MAX};
          r_valid_out <= 1'b1;
          r_count     <= '0;
        end else begin
          r_count <= r_count + 1'b1;
          if (r_pend_v) begin
            r_data_out  <= {1'b0, r_pend};
            r_valid_out <= 1'b1;
            r_pend_v    <= 1'b0;
          end
        end
      end else if (valid_in) begin
        r_last      <= data_in;
        r_valid_out <= 1'b1;
        if (r_count != '0) begin
          r_data_out <= {1'b1, r_count};
          r_pend     <= data_in;
          r_pend_v   <= 1'b1;
          r_count    <= '0;
        end else if (r_pend_v) begin
          r_data_out <= {1'b0, r_pend};
          r_pend     <= data_in;
        end else begin
          r_data_out <= {1'b0, data_in};
        end
      end else if (r_pend_v) begin
        r_data_out  <= {1'b0, r_pend};
        r_valid_out <= 1'b1;
        r_pend_v    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rle_encoder.sv
// tb_rle_encoder: directed stimulus against a word-stream RLE model plus literal timing checks
module tb_rle_encoder;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rle_en = 1'b0;
  logic [7:0] data_in = '0;
  logic       valid_in = 1'b0;
  logic       flush = 1'b0;
  logic [8:0] data_out;
  logic       valid_out;
  logic       flush_done;
  logic       busy;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t0 = 0;
  logic [8:0] exp_q[$];
  logic [8:0] obs_w[$];
  int         obs_c[$];
  int         done_c[$];
  logic [8:0] exp_w;
  logic       m_active = 1'b0;
  logic [7:0] m_last = '0;
  int         m_run = 0;

  rle_encoder #(.SAMPLE_WIDTH(8)) dut (
    .clock(clk), .reset(reset), .rle_en(rle_en), .data_in(data_in),
    .valid_in(valid_in), .flush(flush), .data_out(data_out),
    .valid_out(valid_out), .flush_done(flush_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // every emitted word must be the next word of the model's stream
  always @(negedge clk) begin
    if (valid_out) begin
      obs_w.push_back(data_out);
      obs_c.push_back(cyc);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL stream: unexpected word %h at cycle %0d, none required", data_out, cyc);
      end else begin
        exp_w = exp_q.pop_front();
        if (data_out !== exp_w) begin
          fails++;
          $display("FAIL stream: word %h at cycle %0d, required %h", data_out, cyc, exp_w);
        end
      end
    end
    if (flush_done) done_c.push_back(cyc);
  end

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  function automatic int ow(input int i);
    return (obs_w.size() > i) ? int'(obs_w[i]) : 32'hDEAD;
  endfunction

  function automatic int oc(input int i);
    return (obs_c.size() > i) ? obs_c[i] : -1;
  endfunction

  // RLE semantics as a pure stream transform, no pipeline timing
  task automatic model(input logic v, input logic [7:0] d, input logic f);
    if (f) begin
      if (m_active && m_run > 0) exp_q.push_back({1'b1, 8'(m_run)});
      m_active = 1'b0;
      m_run = 0;
    end else if (v) begin
      if (!m_active) begin
        exp_q.push_back({1'b0, d});
        if (rle_en) begin
          m_active = 1'b1;
          m_last = d;
          m_run = 0;
        end
      end else if (d == m_last) begin
        m_run++;
        if (m_run == 255) begin
          exp_q.push_back(9'h1FF);
          m_run = 0;
        end
      end else begin
        if (m_run > 0) exp_q.push_back({1'b1, 8'(m_run)});
        exp_q.push_back({1'b0, d});
        m_last = d;
        m_run = 0;
      end
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic f);
    valid_in = v;
    data_in = d;
    flush = f;
    model(v, d, f);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic start();
    obs_w.delete();
    obs_c.delete();
    done_c.delete();
    t0 = cyc;
  endtask

  task automatic finish_test(input string nm, input int done_at);
    idle(4);
    chk({nm, " drained"}, exp_q.size(), 0);
    chk({nm, " done count"}, done_c.size(), 1);
    chk({nm, " done cycle"}, (done_c.size() > 0) ? done_c[0] : -1, done_at);
    chk({nm, " busy idle"}, int'(busy), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset data_out", int'(data_out), 0);
    chk("reset valid_out", int'(valid_out), 0);
    chk("reset flush_done", int'(flush_done), 0);
    chk("reset busy", int'(busy), 0);
    reset = 1'b0;
    idle(1);

    start();
    rle_en = 1'b0;
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    idle(3);
    chk("pass words", obs_w.size(), 3);
    chk("pass w0", ow(0), 9'h011);
    chk("pass w1", ow(1), 9'h011);
    chk("pass w2", ow(2), 9'h022);
    chk("pass c0", oc(0), t0 + 1);
    chk("pass c2", oc(2), t0 + 3);
    chk("pass busy", int'(busy), 0);
    chk("pass drained", exp_q.size(), 0);

    start();
    rle_en = 1'b1;
    drive(1'b1, 8'hAA, 1'b0);
    chk("run busy", int'(busy), 1);
    rle_en = 1'b0;
    repeat (4) drive(1'b1, 8'hAA, 1'b0);
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    finish_test("basic", t0 + 8);
    chk("basic words", obs_w.size(), 3);
    chk("basic w0", ow(0), 9'h0AA);
    chk("basic w1", ow(1), 9'h104);
    chk("basic w2", ow(2), 9'h055);
    chk("basic c1", oc(1), t0 + 6);
    chk("basic c2", oc(2), t0 + 7);

    start();
    rle_en = 1'b1;
    repeat (258) drive(1'b1, 8'h3C, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    finish_test("sat", t0 + 260);
    chk("sat words", obs_w.size(), 3);
    chk("sat w0", ow(0), 9'h03C);
    chk("sat w1", ow(1), 9'h1FF);
    chk("sat c1", oc(1), t0 + 256);
    chk("sat w2", ow(2), 9'h102);

    start();
    drive(1'b1, 8'h01, 1'b0);
    drive(1'b1, 8'h02, 1'b0);
    drive(1'b1, 8'h01, 1'b0);
    drive(1'b1, 8'h02, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    finish_test("alt", t0 + 5);
    chk("alt words", obs_w.size(), 4);
    chk("alt w3", ow(3), 9'h002);
    chk("alt c0", oc(0), t0 + 1);
    chk("alt c3", oc(3), t0 + 4);

    start();
    drive(1'b1, 8'h07, 1'b0);
    drive(1'b1, 8'h07, 1'b0);
    drive(1'b1, 8'h09, 1'b0);
    drive(1'b1, 8'h0A, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    finish_test("pend", t0 + 6);
    chk("pend words", obs_w.size(), 4);
    chk("pend w1", ow(1), 9'h101);
    chk("pend w2", ow(2), 9'h009);
    chk("pend w3", ow(3), 9'h00A);
    chk("pend c1", oc(1), t0 + 3);
    chk("pend c3", oc(3), t0 + 5);

    start();
    repeat (10) drive(1'b1, 8'hF0, 1'b0);
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    reset = 1'b0;
    exp_q.delete();
    m_active = 1'b0;
    m_run = 0;
    chk("rst data_out", int'(data_out), 0);
    chk("rst valid_out", int'(valid_out), 0);
    chk("rst flush_done", int'(flush_done), 0);
    chk("rst busy", int'(busy), 0);
    obs_w.delete();
    obs_c.delete();
    t0 = cyc;
    drive(1'b1, 8'hF0, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    finish_test("rst", t0 + 2);
    chk("rst words", obs_w.size(), 1);
    chk("rst w0", ow(0), 9'h0F0);

    start();
    drive(1'b0, 8'h00, 1'b1);
    finish_test("idle flush", t0 + 1);
    chk("idle flush words", obs_w.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
